countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Countdown counterpart to the stopwatch up-counter: loads a seconds preset and counts down at 10 ms resolution to 00:00, then flags completion.
- Sits between the debounced button pulses (run/stop, clear) and the FND controller.
- Its sec/msec outputs drive the same bcd_sec/bcd_msec display inputs as the stopwatch.
- Contains its own run-gated 100 Hz prescaler and control FSM.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, decrement rate in Hz. DIV = CLK_FREQ/TICK_HZ clock cycles per tick.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_run_stop  input  1  one-cycle pulse from the debouncer; start/pause/resume
- i_clear  input  1  one-cycle pulse from the debouncer; abort and reload preset
- i_preset_sec  input  6  preset seconds from switches; values >59 are clamped to 59
- o_msec  output  7  centiseconds remaining, 0..99
- o_sec  output  6  seconds remaining, 0..59
- o_running  output  1  high while in RUN
- o_done  output  1  high while in DONE
- o_expired  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset is asynchronous, active-high, single clock domain (clk). Values during reset:
  - state = IDLE; o_sec = 0; o_msec = 0; prescaler = 0
  - o_running = 0; o_done = 0; o_expired = 0
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered or decoded from the state register.
- IDLE:
  - Each cycle: o_sec <= min(i_preset_sec, 59); o_msec <= 0; prescaler <= 0.
  - i_run_stop with clamped preset != 0 -> RUN.
  - i_run_stop with preset == 0 -> stay in IDLE.
- RUN:
  - Prescaler increments every cycle. When prescaler == DIV-1: prescaler <= 0 and a decrement occurs on that same edge.
  - Decrement rule:
    - msec > 0: msec - 1.
    - msec == 0 and sec > 0: msec <= 99, sec <= sec - 1.
  - If the decrement produces 00:00: state <= DONE on the same edge, and o_expired pulses for the following cycle.
  - i_run_stop -> PAUSE. i_clear -> IDLE.
- PAUSE:
  - Counts and prescaler are held; the prescaler is not reset, so a resumed tick period is not lengthened.
  - i_run_stop -> RUN. i_clear -> IDLE.
- DONE:
  - o_sec = 0, o_msec = 0, o_done = 1.
  - i_run_stop or i_clear -> IDLE, where the preset reloads on the next edge.
- Priority and simultaneous events:
  - i_clear and i_run_stop in the same cycle: i_clear wins in every state.
  - Button pulse coinciding with a tick in RUN: the decrement is applied, then the state transition takes effect.
  - If that decrement reaches 00:00 on the same edge as an i_run_stop: DONE wins over PAUSE.
- Latency:
  - Button pulse to state change: 1 clock.
  - From entering RUN, first decrement after exactly DIV cycles.
  - Full countdown from S seconds = S*TICK_HZ ticks = S*100*DIV cycles.
- i_preset_sec changes outside IDLE are ignored.
- No wrap below zero: counts never underflow; DONE is terminal until a button press.
- Reset asserted mid-RUN or mid-PAUSE: immediate return to IDLE with zeroed outputs; the preset loads on the first edge after release.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, so DIV=10):
- Preset load: reset, set i_preset_sec=5, release reset.
  -> Idle reload: o_sec=5, o_msec=0 after 1 clk; o_running=0.
  -> Live tracking: changing the preset to 70 gives o_sec=59.
- First tick and borrow: preset=2, pulse i_run_stop.
  -> First tick: o_running=1 next clk; after 10 clk, o_sec=1, o_msec=99 (borrow).
  -> Later tick: after 10 more clk, 1:98.
- Full countdown: preset=1, run.
  -> Expiry: exactly 1000 clk after RUN entry, o_sec=0, o_msec=0, o_done=1, o_expired high for exactly 1 clk.
  -> Hold: further clocks keep 00:00 (no underflow).
- Pause and resume: run with preset=3; pulse i_run_stop at prescaler=4; hold 50 clk; pulse again.
  -> Pause: counts frozen during the hold.
  -> Resume: next decrement exactly 6 clk after resume.
- Clear priority: in RUN, pulse i_clear and i_run_stop in the same cycle.
  -> IDLE, o_sec reloads the preset, o_running=0.
  -> Same result from PAUSE and from DONE. A run pulse with preset=0 in IDLE stays in IDLE.
- Async reset mid-run: assert reset between clock edges during RUN.
  -> Outputs zero immediately.
  -> After release, IDLE with the preset loaded in 1 clk; no o_expired pulse.

Source files
------------

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: button, preset and display signals between the control side and the countdown timer
interface countdown_timer_if;
  logic       i_run_stop;
  logic       i_clear;
  logic [5:0] i_preset_sec;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic       o_running;
  logic       o_done;
  logic       o_expired;
  modport master (
    output i_run_stop, i_clear, i_preset_sec,
    input  o_msec, o_sec, o_running, o_done, o_expired
  );
  modport slave (
    input  i_run_stop, i_clear, i_preset_sec,
    output o_msec, o_sec, o_running, o_done, o_expired
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loads a seconds preset and counts down at TICK_HZ to 00:00, then flags completion
module countdown_timer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input logic clk,
  input logic reset,
  countdown_timer_if.slave bus
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    msec_q, msec_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          exp_q, exp_d;
  logic [5:0]    preset_c;
  logic          tick;
  logic [5:0]    dec_sec;
  logic [6:0]    dec_msec;
  logic          dec_zero;
  always_comb begin
    preset_c = (bus.i_preset_sec > 6'd59) ? 6'd59 : bus.i_preset_sec;
    tick     = (state_q == RUN) && (pre_q == PRE_MAX);
    dec_msec = (msec_q != 7'd0) ? msec_q - 7'd1 : ((sec_q != 6'd0) ? 7'd99 : 7'd0);
    dec_sec  = (msec_q == 7'd0 && sec_q != 6'd0) ? sec_q - 6'd1 : sec_q;
    dec_zero = (dec_sec == 6'd0) && (dec_msec == 7'd0);
  end
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    msec_d  = msec_q;
    pre_d   = pre_q;
    exp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sec_d   = preset_c;
        msec_d  = 7'd0;
        pre_d   = '0;
        state_d = (bus.i_run_stop && !bus.i_clear && preset_c != 6'd0) ? RUN : IDLE;
      end
      RUN: begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
        sec_d  = tick ? dec_sec : sec_q;
        msec_d = tick ? dec_msec : msec_q;
        // a decrement that lands on 00:00 outranks a pause request on the same edge
        state_d = bus.i_clear           ? IDLE :
                  (tick && dec_zero)    ? DONE :
                  bus.i_run_stop        ? PAUSE : RUN;
        exp_d  = !bus.i_clear && tick && dec_zero;
      end
      PAUSE: state_d = bus.i_clear ? IDLE : (bus.i_run_stop ? RUN : PAUSE);
      default: begin
        sec_d   = 6'd0;
        msec_d  = 7'd0;
        state_d = (bus.i_clear || bus.i_run_stop) ? IDLE : DONE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= 6'd0;
      msec_q  <= 7'd0;
      pre_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      msec_q  <= msec_d;
      pre_q   <= pre_d;
      exp_q   <= exp_d;
    end
  end
  assign bus.o_sec     = sec_q;
  assign bus.o_msec    = msec_q;
  assign bus.o_running = (state_q == RUN);
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_expired = exp_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench comparing the timer against a remaining-centiseconds reference model
module tb_countdown_timer;
  localparam int DIV = 10;
  typedef struct packed {
    logic [5:0] sec;
    logic [6:0] msec;
    logic       run;
    logic       done;
    logic       expd;
  } obs_t;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  obs_t q[$];
  obs_t want, got;
  int   m_mode, m_rem, m_ph;
  bit   m_exp;
  countdown_timer_if bus();
  countdown_timer #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic obs_t model_out();
    obs_t o;
    o.sec  = 6'(m_rem / 100);
    o.msec = 7'(m_rem % 100);
    o.run  = (m_mode == 1);
    o.done = (m_mode == 3);
    o.expd = m_exp;
    return o;
  endfunction
  task automatic model_reset();
    m_mode = 0;
    m_rem  = 0;
    m_ph   = 0;
    m_exp  = 0;
  endtask
  // modes: 0 idle, 1 run, 2 pause, 3 done; time kept as total centiseconds left
  task automatic model_step(input bit rs, input bit clr, input int preset);
    int p;
    bit tick;
    p = (preset > 59) ? 59 : preset;
    m_exp = 0;
    case (m_mode)
      0: begin
        m_rem = p * 100;
        m_ph  = 0;
        if (rs && !clr && p != 0) m_mode = 1;
      end
      1: begin
        tick = (m_ph == DIV - 1);
        m_ph = tick ? 0 : m_ph + 1;
        if (tick) m_rem = m_rem - 1;
        if (clr) m_mode = 0;
        else if (tick && m_rem == 0) begin
          m_mode = 3;
          m_exp  = 1;
        end else if (rs) m_mode = 2;
      end
      2: if (clr) m_mode = 0; else if (rs) m_mode = 1;
      default: if (rs || clr) m_mode = 0;
    endcase
  endtask
  task automatic cyc(input bit rs, input bit clr);
    bus.i_run_stop = rs;
    bus.i_clear    = clr;
    model_step(rs, clr, int'(bus.i_preset_sec));
    @(posedge clk);
    #1;
    q.push_back(model_out());
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask
  task automatic check_zero(input string name);
    total++;
    if (bus.o_sec !== 6'd0 || bus.o_msec !== 7'd0 || bus.o_running !== 1'b0 ||
        bus.o_done !== 1'b0 || bus.o_expired !== 1'b0) begin
      bad++;
      $display("FAIL %s: got sec=%0d msec=%0d run=%b done=%b exp=%b, want all zero",
               name, bus.o_sec, bus.o_msec, bus.o_running, bus.o_done, bus.o_expired);
    end
  endtask
  // asserted mid-cycle, after the monitor has consumed the last pushed entry
  task automatic do_reset(input int hold);
    #6;
    reset = 1'b1;
    model_reset();
    #1;
    check_zero("async_reset_immediate");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      q.push_back(model_out());
    end
    reset = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        want = q.pop_front();
        got  = {bus.o_sec, bus.o_msec, bus.o_running, bus.o_done, bus.o_expired};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL outputs @%0t: got sec=%0d msec=%0d run=%b done=%b exp=%b, want sec=%0d msec=%0d run=%b done=%b exp=%b",
                   $time, got.sec, got.msec, got.run, got.done, got.expd,
                   want.sec, want.msec, want.run, want.done, want.expd);
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int r;
    reset = 1'b1;
    bus.i_run_stop   = 1'b0;
    bus.i_clear      = 1'b0;
    bus.i_preset_sec = 6'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;
    idle_n(2);
    bus.i_preset_sec = 6'd70;
    idle_n(2);
    bus.i_preset_sec = 6'd2;
    idle_n(1);
    cyc(1'b1, 1'b0);
    idle_n(30);
    cyc(1'b0, 1'b1);
    bus.i_preset_sec = 6'd1;
    idle_n(2);
    cyc(1'b1, 1'b0);
    n = 0;
    while (!bus.o_expired && n < 1100) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    total++;
    if (n != 1000) begin
      bad++;
      $display("FAIL expiry_latency: got %0d cycles, want 1000", n);
    end
    idle_n(20);
    bus.i_preset_sec = 6'd3;
    cyc(1'b1, 1'b1);
    idle_n(2);
    cyc(1'b1, 1'b0);
    idle_n(13);
    cyc(1'b1, 1'b0);
    idle_n(50);
    cyc(1'b1, 1'b0);
    idle_n(30);
    cyc(1'b1, 1'b1);
    idle_n(3);
    cyc(1'b1, 1'b0);
    idle_n(5);
    cyc(1'b1, 1'b0);
    idle_n(5);
    cyc(1'b1, 1'b1);
    idle_n(3);
    bus.i_preset_sec = 6'd0;
    idle_n(1);
    cyc(1'b1, 1'b0);
    idle_n(5);
    bus.i_preset_sec = 6'd2;
    idle_n(1);
    cyc(1'b1, 1'b0);
    idle_n(40);
    do_reset(2);
    idle_n(15);
    for (int i = 0; i < 20000; i++) begin
      r = int'($urandom_range(0, 999));
      if ($urandom_range(0, 49) == 0)
        bus.i_preset_sec = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
      if (r == 999) do_reset(int'($urandom_range(1, 3)));
      else cyc(r < 15 || (r >= 20 && r < 23), (r >= 15 && r < 18) || (r >= 20 && r < 23));
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
